multicycle_control: RTL and testbench
=====================================

# multicycle_control

Parametrised multi-cycle control unit for the RV32 datapath, replacing the single-cycle combinational decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the datapath mux selects, register and memory enables. It stretches memory phases on a ready handshake and detects illegal opcodes and memory timeouts. It sits between the instruction register's opcode field and the shared datapath/memory port.

## Interface
- MEM_TIMEOUT, 15: max cycles waiting for `mem_ready` in FETCH/MEM before bus error; 0 disables the timeout.
- HALT_ON_ILLEGAL, 1: 1 = illegal opcode enters HALT; 0 = pulse `illegal` and return to FETCH.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces state FETCH, clears wait counter and `bus_error`.
- opcode  in  7  IR[6:0], valid from DECODE onward.
- zero  in  1  ALU zero flag, sampled in branch EXEC.
- mem_ready  in  1  memory completes the current request this cycle.
- pc_write  out  1  PC load enable.
- ir_write  out  1  IR load enable.
- pc_src  out  2  00 ALU result, 01 ALUOut register.
- iord  out  1  memory address: 0 PC, 1 ALUOut.
- mem_req / mem_read / mem_write  out  1 each  memory request and direction.
- alusrc_a  out  2  00 PC, 01 rs1, 10 old PC, 11 zero.
- alusrc_b  out  2  00 rs2, 01 constant 4, 10 immediate.
- alu_op  out  2  00 add, 01 branch compare, 10 R-funct, 11 I-funct.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  2  00 ALUOut, 01 memory data, 10 PC (link).
- instr_done  out  1  one-cycle pulse on an instruction's final cycle.
- illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode.
- bus_error  out  1  sticky; set on timeout; cleared only by reset.
- halted  out  1  high in HALT.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Outputs not listed for a state are 0.
- FETCH:
  - Drive mem_req=1, mem_read=1, iord=0, alusrc_a=00, alusrc_b=01, alu_op=00.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=00 (PC←PC+4), go DECODE.
  - Otherwise stay.
- DECODE:
  - Drive alusrc_a=10, alusrc_b=10, alu_op=00 (branch/jal target into ALUOut).
  - Classify opcode into a registered class: R 0110011, IALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111.
  - Legal opcode: go EXEC.
  - Any other opcode: pulse illegal. Go HALT if HALT_ON_ILLEGAL=1, else go FETCH with instr_done=1.
- EXEC, by registered class:
  - R: a=01, b=00, op=10; go WB.
  - IALU: a=01, b=10, op=11; go WB.
  - LUI: a=11, b=10, op=00; go WB.
  - LOAD/STORE: a=01, b=10, op=00; go MEM.
  - BRANCH: a=01, b=00, op=01, pc_src=01, pc_write=zero, instr_done=1; go FETCH.
  - JAL: pc_src=01, pc_write=1, reg_write=1, mem_to_reg=10, instr_done=1; go FETCH.
  - JALR: a=01, b=10, op=00, pc_src=00, pc_write=1, reg_write=1, mem_to_reg=10, instr_done=1; go FETCH.
- MEM:
  - Drive mem_req=1, iord=1, and mem_read (LOAD) or mem_write (STORE).
  - On mem_ready: LOAD goes WB; STORE goes FETCH with instr_done=1.
- WB: reg_write=1, mem_to_reg=01 for LOAD else 00, instr_done=1; go FETCH.
- HALT: only `halted`=1 (bus_error holds its value). Exits only via reset.
- Wait counter:
  - Width $clog2(MEM_TIMEOUT+1).
  - Increments each FETCH/MEM cycle with mem_ready=0; clears on mem_ready or state exit.
  - When the counter equals MEM_TIMEOUT (≠0) and mem_ready=0: set bus_error, go HALT.
  - mem_ready on the same cycle as the timeout wins, i.e. a normal transition.

## Timing
- While reset is high, every output is 0, combinationally gated. The first FETCH request appears in the first cycle after reset deasserts.
- Moore outputs decode the state. Mealy exceptions:
  - ir_write and pc_write in FETCH, qualified by mem_ready.
  - pc_write in branch EXEC, qualified by zero.
  - instr_done in MEM, qualified by mem_ready.
- Cycles per instruction with zero-wait memory:
  - BRANCH/JAL/JALR: 3.
  - R/IALU/LUI/STORE: 4.
  - LOAD: 5.
  - Each wait cycle adds 1.
- mem_req stays high until the mem_ready cycle, and the address select is stable for the whole request.
- Opcode changes after DECODE are ignored; the class is registered.
- Reset mid-MEM aborts the access; no write enable is asserted on the following cycle.

## Test plan
- R-type 0110011 with mem_ready always 1 -> states F,D,E,WB. reg_write=1 only in cycle 4, alu_op=10 in EXEC, instr_done on cycle 4.
- LOAD 0000011 with mem_ready low for 2 cycles in MEM -> MEM lasts 3 cycles with iord=1, mem_read=1. WB follows with mem_to_reg=01. Total 7 cycles.
- BRANCH: zero=1 -> pc_write=1, pc_src=01 in EXEC. zero=0 -> pc_write=0. Both return to FETCH after 3 cycles.
- JAL 1101111 -> EXEC has pc_write=1, reg_write=1, mem_to_reg=10 simultaneously.
- Opcode 1111111 with HALT_ON_ILLEGAL=1 -> illegal pulses in DECODE, halted=1 thereafter. Reset returns to FETCH with all outputs 0 while reset is high.
- MEM_TIMEOUT=3 and mem_ready held 0 in FETCH -> bus_error and halted set after 4 FETCH cycles. Rerun with mem_ready=1 on the 4th cycle -> normal DECODE.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle RV32 control unit: sequences FETCH/DECODE/EXEC/MEM/WB and drives
// datapath selects and enables, with memory-wait stretching, timeout and illegal-opcode trapping.
module multicycle_control #(
  parameter int MEM_TIMEOUT     = 15,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_req,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] alusrc_a,
  output logic [1:0] alusrc_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_error,
  output logic       halted
);
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI} cls_t;

  state_t        state_q, state_d;
  cls_t          cls_q, cls_d, dec_cls;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          berr_q, berr_d;
  logic          dec_legal, wait_st, timeout;

  always_comb begin
    dec_legal = 1'b1;
    dec_cls   = C_R;
    case (opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_IALU;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BRANCH;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: dec_cls = C_JALR;
      7'b0110111: dec_cls = C_LUI;
      default:    dec_legal = 1'b0;
    endcase
  end

  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM);
  // A ready in the timeout cycle still completes the access normally.
  assign timeout = (MEM_TIMEOUT != 0) && wait_st && !mem_ready &&
                   (cnt_q == CW'(MEM_TIMEOUT));

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    berr_d  = berr_q;
    cnt_d   = '0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (dec_legal) begin
          state_d = S_EXEC;
          cls_d   = dec_cls;
        end else begin
          state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_R, C_IALU, C_LUI: state_d = S_WB;
          C_LOAD, C_STORE:    state_d = S_MEM;
          default:            state_d = S_FETCH;
        endcase
      end
      S_MEM:    if (mem_ready) state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_HALT;
    endcase
    if (wait_st && !mem_ready) cnt_d = cnt_q + CW'(1);
    if (timeout) begin
      state_d = S_HALT;
      berr_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cls_q   <= C_R;
      cnt_q   <= '0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
      berr_q  <= berr_d;
    end
  end

  // Outputs decode the state; everything is forced low while reset is high.
  always_comb begin
    pc_write = 1'b0; ir_write = 1'b0; pc_src = 2'b00; iord = 1'b0;
    mem_req = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    alusrc_a = 2'b00; alusrc_b = 2'b00; alu_op = 2'b00;
    reg_write = 1'b0; mem_to_reg = 2'b00; instr_done = 1'b0;
    illegal = 1'b0; bus_error = 1'b0; halted = 1'b0;
    if (!reset) begin
      bus_error = berr_q;
      case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1; mem_read = 1'b1; alusrc_b = 2'b01;
          ir_write = mem_ready; pc_write = mem_ready;
        end
        S_DECODE: begin
          alusrc_a = 2'b10; alusrc_b = 2'b10;
          illegal  = !dec_legal;
          instr_done = !dec_legal && !HALT_ON_ILLEGAL;
        end
        S_EXEC: begin
          case (cls_q)
            C_R:    begin alusrc_a = 2'b01; alusrc_b = 2'b00; alu_op = 2'b10; end
            C_IALU: begin alusrc_a = 2'b01; alusrc_b = 2'b10; alu_op = 2'b11; end
            C_LUI:  begin alusrc_a = 2'b11; alusrc_b = 2'b10; end
            C_LOAD, C_STORE: begin alusrc_a = 2'b01; alusrc_b = 2'b10; end
            C_BRANCH: begin
              alusrc_a = 2'b01; alu_op = 2'b01; pc_src = 2'b01;
              pc_write = zero; instr_done = 1'b1;
            end
            C_JAL: begin
              pc_src = 2'b01; pc_write = 1'b1; reg_write = 1'b1;
              mem_to_reg = 2'b10; instr_done = 1'b1;
            end
            default: begin
              alusrc_a = 2'b01; alusrc_b = 2'b10; pc_write = 1'b1;
              reg_write = 1'b1; mem_to_reg = 2'b10; instr_done = 1'b1;
            end
          endcase
        end
        S_MEM: begin
          mem_req   = 1'b1; iord = 1'b1;
          mem_read  = (cls_q == C_LOAD);
          mem_write = (cls_q == C_STORE);
          instr_done = (cls_q == C_STORE) && mem_ready;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls_q == C_LOAD) ? 2'b01 : 2'b00;
          instr_done = 1'b1;
        end
        default: halted = 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboarded bench for multicycle_control: per-cycle expected output vectors
// are built from the state table, queued when stimulus is driven and popped on sampling.
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       pc_write, ir_write, iord, mem_req, mem_read, mem_write;
  logic [1:0] pc_src, alusrc_a, alusrc_b, alu_op, mem_to_reg;
  logic       reg_write, instr_done, illegal, bus_error, halted;

  typedef struct packed {
    logic pc_write, ir_write; logic [1:0] pc_src;
    logic iord, mem_req, mem_read, mem_write;
    logic [1:0] alusrc_a, alusrc_b, alu_op;
    logic reg_write; logic [1:0] mem_to_reg;
    logic instr_done, illegal, bus_error, halted;
  } ov_t;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
    OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
    OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_BAD = 7'b1111111;

  ov_t obs;
  ov_t exp_q[$];
  int  nchk = 0, nerr = 0;

  multicycle_control #(.MEM_TIMEOUT(3), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .pc_src(pc_src), .iord(iord),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write),
    .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
    .illegal(illegal), .bus_error(bus_error), .halted(halted));

  assign obs = {pc_write, ir_write, pc_src, iord, mem_req, mem_read, mem_write,
                alusrc_a, alusrc_b, alu_op, reg_write, mem_to_reg,
                instr_done, illegal, bus_error, halted};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic ov_t fetch_v(bit rdy, bit be);
    ov_t e = '0;
    e.mem_req = 1; e.mem_read = 1; e.alusrc_b = 2'b01;
    e.ir_write = rdy; e.pc_write = rdy; e.bus_error = be;
    return e;
  endfunction

  function automatic ov_t decode_v(bit ill);
    ov_t e = '0;
    e.alusrc_a = 2'b10; e.alusrc_b = 2'b10; e.illegal = ill;
    return e;
  endfunction

  function automatic ov_t ex_alu(logic [1:0] a, logic [1:0] b, logic [1:0] op);
    ov_t e = '0;
    e.alusrc_a = a; e.alusrc_b = b; e.alu_op = op;
    return e;
  endfunction

  function automatic ov_t mem_v(bit st, bit rdy);
    ov_t e = '0;
    e.mem_req = 1; e.iord = 1; e.mem_read = !st; e.mem_write = st;
    e.instr_done = st & rdy;
    return e;
  endfunction

  function automatic ov_t wb_v(bit ld);
    ov_t e = '0;
    e.reg_write = 1; e.mem_to_reg = ld ? 2'b01 : 2'b00; e.instr_done = 1;
    return e;
  endfunction

  function automatic ov_t halt_v(bit be);
    ov_t e = '0;
    e.halted = 1; e.bus_error = be;
    return e;
  endfunction

  // Drive one cycle's inputs at the falling edge, queue its expectation, sample 2ns later.
  task automatic step(input string tag, input bit r, input logic [6:0] opc,
                      input bit rdy, input bit z, input ov_t e);
    ov_t x;
    @(negedge clk);
    reset = r; opcode = opc; mem_ready = rdy; zero = z;
    exp_q.push_back(e);
    #2;
    x = exp_q.pop_front();
    chk(tag, obs, x);
  endtask

  initial begin
    ov_t e;
    step("rst_gate", 1, OP_R, 1, 1, '0);
    step("rst_gate2", 1, OP_LD, 1, 0, '0);

    // R-type, zero-wait: F D E WB
    step("r_f", 0, OP_R, 1, 0, fetch_v(1, 0));
    step("r_d", 0, OP_R, 1, 0, decode_v(0));
    step("r_e", 0, OP_BAD, 1, 0, ex_alu(2'b01, 2'b00, 2'b10));
    step("r_wb", 0, OP_LD, 1, 0, wb_v(0));

    // LOAD with two MEM wait cycles: 7 cycles
    step("ld_f", 0, OP_LD, 1, 0, fetch_v(1, 0));
    step("ld_d", 0, OP_LD, 0, 0, decode_v(0));
    step("ld_e", 0, OP_LD, 0, 0, ex_alu(2'b01, 2'b10, 2'b00));
    step("ld_m0", 0, OP_LD, 0, 0, mem_v(0, 0));
    step("ld_m1", 0, OP_LD, 0, 0, mem_v(0, 0));
    step("ld_m2", 0, OP_LD, 1, 0, mem_v(0, 1));
    step("ld_wb", 0, OP_LD, 1, 0, wb_v(1));

    // STORE zero-wait
    step("st_f", 0, OP_ST, 1, 0, fetch_v(1, 0));
    step("st_d", 0, OP_ST, 1, 0, decode_v(0));
    step("st_e", 0, OP_ST, 1, 0, ex_alu(2'b01, 2'b10, 2'b00));
    step("st_m", 0, OP_ST, 1, 0, mem_v(1, 1));

    // BRANCH taken then not taken
    for (int z = 1; z >= 0; z--) begin
      step("br_f", 0, OP_BR, 1, 0, fetch_v(1, 0));
      step("br_d", 0, OP_BR, 1, 0, decode_v(0));
      e = ex_alu(2'b01, 2'b00, 2'b01);
      e.pc_src = 2'b01; e.pc_write = z[0]; e.instr_done = 1;
      step(z ? "br_e_taken" : "br_e_not", 0, OP_BR, 1, z[0], e);
    end

    // JAL
    step("jal_f", 0, OP_JAL, 1, 0, fetch_v(1, 0));
    step("jal_d", 0, OP_JAL, 1, 0, decode_v(0));
    e = '0; e.pc_src = 2'b01; e.pc_write = 1; e.reg_write = 1;
    e.mem_to_reg = 2'b10; e.instr_done = 1;
    step("jal_e", 0, OP_JAL, 1, 0, e);

    // JALR
    step("jalr_f", 0, OP_JALR, 1, 0, fetch_v(1, 0));
    step("jalr_d", 0, OP_JALR, 1, 0, decode_v(0));
    e = ex_alu(2'b01, 2'b10, 2'b00); e.pc_write = 1; e.reg_write = 1;
    e.mem_to_reg = 2'b10; e.instr_done = 1;
    step("jalr_e", 0, OP_JALR, 1, 0, e);

    // IALU
    step("i_f", 0, OP_I, 1, 0, fetch_v(1, 0));
    step("i_d", 0, OP_I, 1, 0, decode_v(0));
    step("i_e", 0, OP_I, 1, 0, ex_alu(2'b01, 2'b10, 2'b11));
    step("i_wb", 0, OP_I, 1, 0, wb_v(0));

    // LUI with fetch ready arriving exactly on the timeout cycle
    step("lui_fw0", 0, OP_LUI, 0, 0, fetch_v(0, 0));
    step("lui_fw1", 0, OP_LUI, 0, 0, fetch_v(0, 0));
    step("lui_fw2", 0, OP_LUI, 0, 0, fetch_v(0, 0));
    step("lui_f", 0, OP_LUI, 1, 0, fetch_v(1, 0));
    step("lui_d", 0, OP_LUI, 1, 0, decode_v(0));
    step("lui_e", 0, OP_LUI, 1, 0, ex_alu(2'b11, 2'b10, 2'b00));
    step("lui_wb", 0, OP_LUI, 1, 0, wb_v(0));

    // Fetch timeout: four unanswered cycles, then HALT with sticky bus_error
    for (int i = 0; i < 4; i++) step("to_f", 0, OP_R, 0, 0, fetch_v(0, 0));
    step("to_halt", 0, OP_R, 1, 0, halt_v(1));
    step("to_halt2", 0, OP_R, 1, 0, halt_v(1));
    step("to_rst", 1, OP_R, 1, 0, '0);
    step("to_after", 0, OP_R, 0, 0, fetch_v(0, 0));
    step("to_after2", 0, OP_R, 1, 0, fetch_v(1, 0));
    step("to_dec", 0, OP_LUI, 1, 0, decode_v(0));
    step("to_e", 0, OP_LUI, 1, 0, ex_alu(2'b11, 2'b10, 2'b00));
    step("to_wb", 0, OP_LUI, 1, 0, wb_v(0));

    // Reset in the middle of a STORE's MEM phase
    step("mr_f", 0, OP_ST, 1, 0, fetch_v(1, 0));
    step("mr_d", 0, OP_ST, 1, 0, decode_v(0));
    step("mr_e", 0, OP_ST, 1, 0, ex_alu(2'b01, 2'b10, 2'b00));
    step("mr_m", 0, OP_ST, 0, 0, mem_v(1, 0));
    step("mr_rst", 1, OP_ST, 1, 0, '0);
    step("mr_after", 0, OP_ST, 0, 0, fetch_v(0, 0));

    // Illegal opcode halts
    step("ill_f", 0, OP_BAD, 1, 0, fetch_v(1, 0));
    step("ill_d", 0, OP_BAD, 1, 0, decode_v(1));
    step("ill_h0", 0, OP_R, 1, 0, halt_v(0));
    step("ill_h1", 0, OP_R, 1, 0, halt_v(0));
    step("ill_rst", 1, OP_R, 1, 0, '0);
    step("ill_after", 0, OP_R, 1, 0, fetch_v(1, 0));
    step("ill_dec", 0, OP_R, 1, 0, decode_v(0));

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
